// File: rtl/spi_req_arbiter.sv
// -----------------------------------------------------------------------------
// spi_req_arbiter
//
// Purpose:
//   Wishbone master that lets NREQ client requesters share one SPI master core.
//   Requesters are served in round-robin order. For each granted request the
//   block programs the core (SS, TX0, CTRL with GO), polls CTRL until GO
//   clears, reads RX0, releases SS and hands the received word back with a
//   one-cycle done pulse. DIVIDER is written once after every reset.
//
// Parameters:
//   NREQ         number of requesters (2..8); requester i drives SS bit i
//   DIVIDER      value written to DIVIDER[15:0] after reset
//   ACK_TIMEOUT  cycles to wait for m_ack_in before an access is abandoned
//
// Ports:
//   wb_clk_in    clock
//   wb_rst_n_in  asynchronous reset, active low
//   req_in       per-requester pending flag
//   req_data_in  per-requester TX word       (requester i at [32i+31:32i])
//   req_len_in   per-requester bit count     (requester i at [7i+6:7i])
//   req_mode_in  per-requester {lsb, tx_negedge, rx_negedge} (at [3i+2:3i])
//   done_out     one-cycle pulse on the bit of the finished requester
//   err_out      one-cycle pulse with done_out when the transfer was aborted
//   rdata_out    RX0 word of the finished transfer (0 when aborted)
//   busy_out     high from grant until the done pulse
//   m_*          Wishbone master port towards the SPI core's slave port
// -----------------------------------------------------------------------------
module spi_req_arbiter #(
  parameter int          NREQ        = 4,
  parameter logic [15:0] DIVIDER     = 16'd1,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic                 wb_clk_in,
  input  logic                 wb_rst_n_in,
  input  logic [NREQ-1:0]      req_in,
  input  logic [NREQ*32-1:0]   req_data_in,
  input  logic [NREQ*7-1:0]    req_len_in,
  input  logic [NREQ*3-1:0]    req_mode_in,
  output logic [NREQ-1:0]      done_out,
  output logic                 err_out,
  output logic [31:0]          rdata_out,
  output logic                 busy_out,
  output logic                 m_cyc_out,
  output logic                 m_stb_out,
  output logic                 m_we_out,
  output logic [4:0]           m_addr_out,
  output logic [31:0]          m_data_out,
  output logic [3:0]           m_sel_out,
  input  logic [31:0]          m_data_in,
  input  logic                 m_ack_in
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  // SPI core register map
  localparam logic [4:0] A_TXRX = 5'h00;
  localparam logic [4:0] A_CTRL = 5'h10;
  localparam logic [4:0] A_DIV  = 5'h14;
  localparam logic [4:0] A_SS   = 5'h18;

  typedef enum logic [3:0] {
    S_INIT,
    S_ARB,
    S_W_SS,
    S_W_TX,
    S_W_CTRL,
    S_POLL,
    S_RD_RX,
    S_W_SSCLR,
    S_DONE
  } state_t;

  // The core treats a zero length as 32 bits; anything above 32 is
  // meaningless to it, so both are forced to a full word.
  function automatic logic [6:0] f_coerce_len(input logic [6:0] len);
    return ((len == 7'd0) || (len > 7'd32)) ? 7'd32 : len;
  endfunction

  // Control state
  state_t             r_state;
  logic [IW-1:0]      r_rr;
  logic [IW-1:0]      r_idx;
  logic               r_err;
  logic               r_ssclr_retry;
  logic               r_wait;
  logic [TW-1:0]      r_tmo;

  // Registered bus and client outputs
  logic               r_cyc;
  logic               r_stb;
  logic               r_we;
  logic [4:0]         r_addr;
  logic [31:0]        r_wdat;
  logic [3:0]         r_sel;
  logic [NREQ-1:0]    r_done;
  logic               r_err_o;
  logic [31:0]        r_rdata;
  logic               r_busy;

  // Request fields captured at grant (no reset needed: only read after a grant)
  logic [31:0]        r_data;
  logic [6:0]         r_len;
  logic [2:0]         r_mode;

  // Combinational arbitration and access selection
  logic               w_any;
  logic [IW-1:0]      w_gidx;
  logic [IW:0]        w_sum;
  logic [IW-1:0]      w_next_rr;
  logic               w_grant;
  logic               w_launch;
  logic               w_we;
  logic [4:0]         w_addr;
  logic [31:0]        w_wdat;
  logic [31:0]        w_ctrl;

  // ---------------------------------------------------------------------------
  // Round-robin search: first pending requester at or after r_rr. Scanning
  // from the farthest offset down lets the nearest one win the last write.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_sum  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) begin
        w_sum = w_sum - (IW+1)'(NREQ);
      end
      if (req_in[w_sum[IW-1:0]]) begin
        w_any  = 1'b1;
        w_gidx = w_sum[IW-1:0];
      end
    end
  end

  assign w_next_rr = (w_gidx == IW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
  assign w_grant   = (r_state == S_ARB) && !r_cyc && w_any;

  // CTRL: {ass=0, ie=0, lsb, tx_neg, rx_neg, go=1, 1'b0, len[6:0]}
  assign w_ctrl = {18'd0, 1'b0, 1'b0, r_mode[2], r_mode[1], r_mode[0],
                   1'b1, 1'b0, r_len};

  // ---------------------------------------------------------------------------
  // Which access (if any) the current state wants to start once the bus is
  // idle. POLL holds off until two idle cycles have passed.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_launch = 1'b0;
    w_we     = 1'b1;
    w_addr   = 5'h00;
    w_wdat   = 32'd0;
    case (r_state)
      S_INIT: begin
        w_launch = 1'b1;
        w_addr   = A_DIV;
        w_wdat   = {16'd0, DIVIDER};
      end
      S_W_SS: begin
        w_launch = 1'b1;
        w_addr   = A_SS;
        w_wdat   = 32'd1 << r_idx;
      end
      S_W_TX: begin
        w_launch = 1'b1;
        w_addr   = A_TXRX;
        w_wdat   = r_data;
      end
      S_W_CTRL: begin
        w_launch = 1'b1;
        w_addr   = A_CTRL;
        w_wdat   = w_ctrl;
      end
      S_POLL: begin
        w_launch = r_wait;
        w_we     = 1'b0;
        w_addr   = A_CTRL;
      end
      S_RD_RX: begin
        w_launch = 1'b1;
        w_we     = 1'b0;
        w_addr   = A_TXRX;
      end
      S_W_SSCLR: begin
        w_launch = 1'b1;
        w_addr   = A_SS;
        w_wdat   = 32'd0;
      end
      default: begin
        w_launch = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Grant capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_in) begin
    if (w_grant) begin
      r_data <= req_data_in[32*int'(w_gidx) +: 32];
      r_len  <= f_coerce_len(req_len_in[7*int'(w_gidx) +: 7]);
      r_mode <= req_mode_in[3*int'(w_gidx) +: 3];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer and Wishbone engine. An access is held until ack; the bus is
  // released on the ack edge, so the following cycle is always idle before
  // the next state may launch its own access.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_in or negedge wb_rst_n_in) begin
    if (!wb_rst_n_in) begin
      r_state       <= S_INIT;
      r_rr          <= '0;
      r_idx         <= '0;
      r_err         <= 1'b0;
      r_ssclr_retry <= 1'b0;
      r_wait        <= 1'b0;
      r_tmo         <= '0;
      r_cyc         <= 1'b0;
      r_stb         <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= 5'h00;
      r_wdat        <= 32'd0;
      r_sel         <= 4'h0;
      r_done        <= '0;
      r_err_o       <= 1'b0;
      r_rdata       <= 32'd0;
      r_busy        <= 1'b0;
    end else begin
      r_done  <= '0;
      r_err_o <= 1'b0;

      if (r_cyc) begin
        if (m_ack_in) begin
          r_cyc  <= 1'b0;
          r_stb  <= 1'b0;
          r_we   <= 1'b0;
          r_addr <= 5'h00;
          r_wdat <= 32'd0;
          r_sel  <= 4'h0;
          r_tmo  <= '0;
          case (r_state)
            S_INIT:    r_state <= S_ARB;
            S_W_SS:    r_state <= S_W_TX;
            S_W_TX:    r_state <= S_W_CTRL;
            S_W_CTRL: begin
              r_state <= S_POLL;
              r_wait  <= 1'b0;
            end
            S_POLL: begin
              // GO still set: go round again after another idle gap
              if (m_data_in[8]) begin
                r_wait <= 1'b0;
              end else begin
                r_state <= S_RD_RX;
              end
            end
            S_RD_RX: begin
              r_rdata <= m_data_in;
              r_state <= S_W_SSCLR;
            end
            S_W_SSCLR: r_state <= S_DONE;
            default:   r_state <= S_ARB;
          endcase
        end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
          r_cyc  <= 1'b0;
          r_stb  <= 1'b0;
          r_we   <= 1'b0;
          r_addr <= 5'h00;
          r_wdat <= 32'd0;
          r_sel  <= 4'h0;
          r_tmo  <= '0;
          if (r_state == S_INIT) begin
            r_state <= S_INIT;
          end else if (r_state == S_W_SSCLR) begin
            // Clearing SS gets one second chance, then the transfer ends anyway
            r_err <= 1'b1;
            if (r_ssclr_retry) begin
              r_state <= S_DONE;
            end else begin
              r_ssclr_retry <= 1'b1;
            end
          end else begin
            r_err   <= 1'b1;
            r_state <= S_W_SSCLR;
          end
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        case (r_state)
          S_ARB: begin
            if (w_any) begin
              r_idx         <= w_gidx;
              r_rr          <= w_next_rr;
              r_busy        <= 1'b1;
              r_err         <= 1'b0;
              r_ssclr_retry <= 1'b0;
              r_state       <= S_W_SS;
            end
          end
          S_POLL: begin
            if (!r_wait) begin
              r_wait <= 1'b1;
            end
          end
          S_DONE: begin
            r_done  <= NREQ'(1) << r_idx;
            r_err_o <= r_err;
            if (r_err) begin
              r_rdata <= 32'd0;
            end
            r_busy  <= 1'b0;
            r_state <= S_ARB;
          end
          default: begin
          end
        endcase

        if (w_launch) begin
          r_cyc  <= 1'b1;
          r_stb  <= 1'b1;
          r_we   <= w_we;
          r_addr <= w_addr;
          r_wdat <= w_we ? w_wdat : 32'd0;
          r_sel  <= 4'hF;
          r_tmo  <= '0;
        end
      end
    end
  end

  assign done_out   = r_done;
  assign err_out    = r_err_o;
  assign rdata_out  = r_rdata;
  assign busy_out   = r_busy;
  assign m_cyc_out  = r_cyc;
  assign m_stb_out  = r_stb;
  assign m_we_out   = r_we;
  assign m_addr_out = r_addr;
  assign m_data_out = r_wdat;
  assign m_sel_out  = r_sel;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_req_arbiter
//
// Bench for spi_req_arbiter. A behavioural SPI-core register model answers the
// Wishbone accesses (one-cycle ack, loopback RX = TX masked to the bit count,
// GO self-clears after a while). Single-requester transfers are driven from a
// vector table; round-robin, ack timeout and reset-in-POLL are hand sequences.
// -----------------------------------------------------------------------------
module tb_spi_req_arbiter;

  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_in = '0;
  logic [NREQ*32-1:0]   req_data_in = '0;
  logic [NREQ*7-1:0]    req_len_in = '0;
  logic [NREQ*3-1:0]    req_mode_in = '0;
  logic [NREQ-1:0]      done_out;
  logic                 err_out;
  logic [31:0]          rdata_out;
  logic                 busy_out;
  logic                 m_cyc, m_stb, m_we;
  logic [4:0]           m_addr;
  logic [31:0]          m_wdata;
  logic [3:0]           m_sel;
  logic [31:0]          s_rdata;
  logic                 s_ack;

  always #5 clk = ~clk;

  spi_req_arbiter #(.NREQ(NREQ), .DIVIDER(16'd1), .ACK_TIMEOUT(64)) dut (
    .wb_clk_in   (clk),
    .wb_rst_n_in (rst_n),
    .req_in      (req_in),
    .req_data_in (req_data_in),
    .req_len_in  (req_len_in),
    .req_mode_in (req_mode_in),
    .done_out    (done_out),
    .err_out     (err_out),
    .rdata_out   (rdata_out),
    .busy_out    (busy_out),
    .m_cyc_out   (m_cyc),
    .m_stb_out   (m_stb),
    .m_we_out    (m_we),
    .m_addr_out  (m_addr),
    .m_data_out  (m_wdata),
    .m_sel_out   (m_sel),
    .m_data_in   (s_rdata),
    .m_ack_in    (s_ack)
  );

  // ---------------- SPI core register model ----------------
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wlog[$];
  logic [31:0] s_tx, s_rx, s_ctrl, s_div, s_ss;
  int          s_busy;
  logic        s_noack_tx = 1'b0;
  int          n_done = 0;

  function automatic int eff_len(input logic [6:0] l);
    return ((l == 7'd0) || (l > 7'd32)) ? 32 : int'(l);
  endfunction

  function automatic logic [31:0] len_mask(input logic [6:0] l);
    logic [63:0] m;
    m = (64'd1 << eff_len(l)) - 64'd1;
    return m[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack   <= 1'b0;
      s_rdata <= 32'd0;
      s_tx    <= 32'd0;
      s_rx    <= 32'd0;
      s_ctrl  <= 32'd0;
      s_div   <= 32'd0;
      s_ss    <= 32'd0;
      s_busy  <= 0;
    end else begin
      s_ack <= 1'b0;
      if (s_busy > 0) begin
        s_busy <= s_busy - 1;
        if (s_busy == 1) begin
          s_ctrl[8] <= 1'b0;
          s_rx      <= s_tx & len_mask(s_ctrl[6:0]);
        end
      end
      if (m_cyc && m_stb && !s_ack && !(s_noack_tx && m_we && m_addr == 5'h00)) begin
        s_ack <= 1'b1;
        if (m_we) begin
          wlog.push_back({m_addr, m_wdata});
          case (m_addr)
            5'h00: s_tx <= m_wdata;
            5'h10: begin
              s_ctrl <= m_wdata;
              if (m_wdata[8]) s_busy <= 2 * eff_len(m_wdata[6:0]) + 4;
            end
            5'h14: s_div <= m_wdata;
            5'h18: s_ss  <= m_wdata;
            default: ;
          endcase
        end else begin
          case (m_addr)
            5'h00:   s_rdata <= s_rx;
            5'h10:   s_rdata <= s_ctrl;
            5'h14:   s_rdata <= s_div;
            5'h18:   s_rdata <= s_ss;
            default: s_rdata <= 32'd0;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done_out != '0) n_done <= n_done + 1;
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int maxc, output logic [NREQ-1:0] d,
                           output logic e, output logic [31:0] rd);
    d = '0; e = 1'b0; rd = 32'd0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done_out != '0) begin
        d = done_out; e = err_out; rd = rdata_out;
        break;
      end
    end
  endtask

  task automatic wait_wlog(input int n, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (wlog.size() >= n) break;
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] data,
                         input logic [6:0] len, input logic [2:0] mode);
    req_data_in[32*idx +: 32] = data;
    req_len_in[7*idx +: 7]    = len;
    req_mode_in[3*idx +: 3]   = mode;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    wlog.delete();
    rst_n = 1'b1;
    wait_wlog(1, 50);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [6:0]  len;
    logic [2:0]  mode;
    logic [31:0] ctrl;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[5];

  initial begin
    logic [NREQ-1:0] d;
    logic            e;
    logic [31:0]     rd;
    int              nd0;
    int              nss;

    tv[0] = '{1, 32'h000000A5, 7'd8,  3'b000, 32'h00000108, 32'h000000A5};
    tv[1] = '{0, 32'h12345678, 7'd0,  3'b000, 32'h00000120, 32'h12345678};
    tv[2] = '{2, 32'hDEADBEEF, 7'd40, 3'b000, 32'h00000120, 32'hDEADBEEF};
    tv[3] = '{3, 32'hFFFF0F0F, 7'd12, 3'b111, 32'h00000F0C, 32'h00000F0F};
    tv[4] = '{1, 32'h0000ABCD, 7'd16, 3'b100, 32'h00000910, 32'h0000ABCD};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_cyc",   {31'd0, m_cyc}, 32'd0);
    chk("rst_stb",   {31'd0, m_stb}, 32'd0);
    chk("rst_we",    {31'd0, m_we}, 32'd0);
    chk("rst_sel",   {28'd0, m_sel}, 32'd0);
    chk("rst_done",  {28'd0, done_out}, 32'd0);
    chk("rst_busy",  {31'd0, busy_out}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);

    // ---- DIVIDER programmed first ----
    rst_n = 1'b1;
    wait_wlog(1, 50);
    repeat (10) @(negedge clk);
    chk("init_nwrites", wlog.size(), 32'd1);
    if (wlog.size() >= 1) begin
      chk("init_addr", {27'd0, wlog[0].addr}, 32'h14);
      chk("init_data", wlog[0].data, 32'h1);
    end
    chk("init_idle_cyc",  {31'd0, m_cyc}, 32'd0);
    chk("init_idle_busy", {31'd0, busy_out}, 32'd0);

    // ---- single-requester transfers from the table ----
    for (int v = 0; v < 5; v++) begin
      wlog.delete();
      set_req(tv[v].idx, tv[v].data, tv[v].len, tv[v].mode);
      req_in = NREQ'(1) << tv[v].idx;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_busy", v), {31'd0, busy_out}, 32'd1);
      wait_done(600, d, e, rd);
      req_in = '0;
      chk($sformatf("v%0d_done", v), {28'd0, d}, 32'd1 << tv[v].idx);
      chk($sformatf("v%0d_err", v), {31'd0, e}, 32'd0);
      chk($sformatf("v%0d_rdata", v), rd, tv[v].rd);
      chk($sformatf("v%0d_nwrites", v), wlog.size(), 32'd4);
      if (wlog.size() >= 4) begin
        chk($sformatf("v%0d_ss", v),    {wlog[0].addr, 27'd0} | 32'(wlog[0].data), {5'h18, 27'd0} | (32'd1 << tv[v].idx));
        chk($sformatf("v%0d_tx", v),    wlog[1].data, tv[v].data);
        chk($sformatf("v%0d_txa", v),   {27'd0, wlog[1].addr}, 32'h00);
        chk($sformatf("v%0d_ctrl", v),  wlog[2].data, tv[v].ctrl);
        chk($sformatf("v%0d_ctrla", v), {27'd0, wlog[2].addr}, 32'h10);
        chk($sformatf("v%0d_ssclr", v), {wlog[3].addr, 27'd0} | 32'(wlog[3].data), {5'h18, 27'd0});
      end
      @(negedge clk);
      chk($sformatf("v%0d_busy_end", v), {31'd0, busy_out}, 32'd0);
    end

    // ---- all four requesting: round-robin from requester 0 ----
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h11 * (i + 1), 7'd8, 3'b000);
    wlog.delete();
    nd0 = n_done;
    req_in = '1;
    for (int t = 0; t < 5; t++) begin
      wait_done(600, d, e, rd);
      if (t == 4) req_in = '0;
      chk($sformatf("rr%0d_done", t), {28'd0, d}, 32'd1 << (t % 4));
      chk($sformatf("rr%0d_rdata", t), rd, 32'h11 * ((t % 4) + 1));
    end
    req_in = '0;
    repeat (20) @(negedge clk);
    chk("rr_pulses", n_done - nd0, 32'd5);
    nss = 0;
    foreach (wlog[k]) if (wlog[k].addr == 5'h18 && wlog[k].data != 0) nss++;
    chk("rr_ss_writes", nss, 32'd5);

    // ---- TX0 write never acked: timeout, error done ----
    wlog.delete();
    s_noack_tx = 1'b1;
    set_req(2, 32'h00005555, 7'd8, 3'b000);
    req_in = 4'b0100;
    begin
      int cnt;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (m_stb && m_we && m_addr == 5'h00) begin seen = 1'b1; break; end
      end
      chk("to_tx_started", {31'd0, seen}, 32'd1);
      cnt = 0;
      while (m_stb && cnt < 200) begin cnt++; @(negedge clk); end
      chk("to_stb_cycles", cnt, 32'd64);
    end
    wait_done(200, d, e, rd);
    req_in = '0;
    s_noack_tx = 1'b0;
    chk("to_done",  {28'd0, d}, 32'b0100);
    chk("to_err",   {31'd0, e}, 32'd1);
    chk("to_rdata", rd, 32'd0);
    chk("to_nwrites", wlog.size(), 32'd2);
    if (wlog.size() >= 2)
      chk("to_ssclr", {wlog[1].addr, 27'd0} | 32'(wlog[1].data), {5'h18, 27'd0});
    @(negedge clk);
    chk("to_err_pulse", {31'd0, err_out}, 32'd0);

    // ---- asynchronous reset while polling ----
    set_req(0, 32'h0000003C, 7'd8, 3'b000);
    req_in = 4'b0001;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (m_stb && !m_we && m_addr == 5'h10) begin seen = 1'b1; break; end
      end
      chk("ar_poll_seen", {31'd0, seen}, 32'd1);
    end
    nd0 = n_done;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cyc",  {31'd0, m_cyc}, 32'd0);
    chk("ar_stb",  {31'd0, m_stb}, 32'd0);
    chk("ar_sel",  {28'd0, m_sel}, 32'd0);
    chk("ar_addr", {27'd0, m_addr}, 32'd0);
    chk("ar_busy", {31'd0, busy_out}, 32'd0);
    chk("ar_rdata", rdata_out, 32'd0);
    req_in = '0;
    repeat (5) @(negedge clk);
    chk("ar_no_done", n_done - nd0, 32'd0);
    wlog.delete();
    rst_n = 1'b1;
    wait_wlog(1, 50);
    chk("ar_nwrites", wlog.size(), 32'd1);
    if (wlog.size() >= 1) begin
      chk("ar_div_addr", {27'd0, wlog[0].addr}, 32'h14);
      chk("ar_div_data", wlog[0].data, 32'h1);
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
